// File: rtl/calc_sequencer.sv
// Keypad calculator sequencer: BCD operand entry, ALU handshake, result display.
// Define CALC_CHAIN_EN to let an operator key in SHOW chain onto the result.
module calc_sequencer #(
    parameter int NDIG        = 4,
    parameter int ALU_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_valid,
    input  logic [3:0]        key_code,
    output logic              alu_start,
    output logic [1:0]        alu_op,
    output logic [4*NDIG-1:0] operand_a,
    output logic [4*NDIG-1:0] operand_b,
    input  logic              alu_done,
    input  logic              alu_err,
    input  logic [4*NDIG-1:0] alu_result,
    output logic [4*NDIG-1:0] display,
    output logic [2:0]        digit_count,
    output logic              error,
    output logic [2:0]        state_dbg
);

    localparam int W  = 4 * NDIG;
    localparam int CW = $clog2(ALU_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ENTER_A  = 3'd0,
        OP_WAIT  = 3'd1,
        ENTER_B  = 3'd2,
        START    = 3'd3,
        WAIT_ALU = 3'd4,
        SHOW     = 3'd5,
        ERROR    = 3'd6
    } state_t;

    state_t         state, state_n;
    logic           key_prev;
    logic [W-1:0]   opa, opa_n;
    logic [W-1:0]   opb, opb_n;
    logic [W-1:0]   res, res_n;
    logic [W-1:0]   hold;
    logic [1:0]     op, op_n;
    logic [2:0]     dc, dc_n;
    logic [CW-1:0]  cnt, cnt_n;

    logic key_ev;
    logic is_digit, is_op, is_eq, is_clr;
    logic [1:0] op_code;
    logic full;

    assign key_ev = key_valid & ~key_prev;
    assign full   = (dc == 3'(NDIG));

    always_comb begin
        is_digit = 1'b0;
        is_op    = 1'b0;
        is_eq    = 1'b0;
        is_clr   = 1'b0;
        op_code  = 2'd0;
        unique case (1'b1)
            (key_code <= 4'd9): is_digit = key_ev;
            (key_code == 4'hE): is_eq    = key_ev;
            (key_code == 4'hF): is_clr   = key_ev;
            default:            is_op    = key_ev;
        endcase
        case (key_code)
            4'hA:    op_code = 2'd0;
            4'hB:    op_code = 2'd1;
            4'hC:    op_code = 2'd2;
            default: op_code = 2'd3;
        endcase
    end

    always_comb begin
        state_n = state;
        opa_n   = opa;
        opb_n   = opb;
        res_n   = res;
        op_n    = op;
        dc_n    = dc;
        cnt_n   = cnt;
        // Clear is honoured everywhere except while the ALU owns the operands.
        if (is_clr && state != WAIT_ALU) begin
            state_n = ENTER_A;
            opa_n   = '0;
            opb_n   = '0;
            res_n   = '0;
            op_n    = 2'd0;
            dc_n    = 3'd0;
        end else begin
            unique case (state)
                ENTER_A: begin
                    if (is_digit && !full) begin
                        opa_n = {opa[W-5:0], key_code};
                        dc_n  = dc + 3'd1;
                    end else if (is_op && dc != 3'd0) begin
                        op_n    = op_code;
                        dc_n    = 3'd0;
                        state_n = ENTER_B;
                    end
                end
                ENTER_B: begin
                    if (is_digit && !full) begin
                        opb_n = {opb[W-5:0], key_code};
                        dc_n  = dc + 3'd1;
                    end else if (is_op && dc == 3'd0) begin
                        op_n = op_code;
                    end else if (is_eq && dc != 3'd0) begin
                        cnt_n   = '0;
                        state_n = START;
                    end
                end
                START: begin
                    cnt_n   = cnt + 1'b1;
                    state_n = WAIT_ALU;
                end
                WAIT_ALU: begin
                    if (alu_done) begin
                        if (alu_err) begin
                            state_n = ERROR;
                        end else begin
                            res_n   = alu_result;
                            state_n = SHOW;
                        end
                    end else if (cnt >= CW'(ALU_TIMEOUT - 1)) begin
                        state_n = ERROR;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                SHOW: begin
                    if (is_digit) begin
                        opa_n   = W'(key_code);
                        opb_n   = '0;
                        dc_n    = 3'd1;
                        state_n = ENTER_A;
                    end
`ifdef CALC_CHAIN_EN
                    else if (is_op) begin
                        opa_n   = res;
                        opb_n   = '0;
                        op_n    = op_code;
                        dc_n    = 3'd0;
                        state_n = OP_WAIT;
                    end
`endif
                end
                OP_WAIT: begin
`ifdef CALC_CHAIN_EN
                    if (is_digit) begin
                        opb_n   = W'(key_code);
                        dc_n    = 3'd1;
                        state_n = ENTER_B;
                    end else if (is_op) begin
                        op_n = op_code;
                    end
`else
                    state_n = ENTER_A;
`endif
                end
                ERROR: begin
                    state_n = ERROR;
                end
                default: begin
                    state_n = ENTER_A;
                end
            endcase
        end
    end

    always_comb begin
        display = hold;
        unique case (state)
            ENTER_A, OP_WAIT: display = opa;
            ENTER_B:          display = opb;
            SHOW:             display = res;
            ERROR:            display = '1;
            default:          display = hold;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ENTER_A;
            key_prev <= 1'b0;
            opa      <= '0;
            opb      <= '0;
            res      <= '0;
            hold     <= '0;
            op       <= 2'd0;
            dc       <= 3'd0;
            cnt      <= '0;
        end else begin
            state    <= state_n;
            key_prev <= key_valid;
            opa      <= opa_n;
            opb      <= opb_n;
            res      <= res_n;
            hold     <= display;
            op       <= op_n;
            dc       <= dc_n;
            cnt      <= cnt_n;
        end
    end

    assign alu_start   = (state == START);
    assign alu_op      = op;
    assign operand_a   = opa;
    assign operand_b   = opb;
    assign digit_count = dc;
    assign error       = (state == ERROR);
    assign state_dbg   = state;

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: directed key sequences, ALU responder,
// and a monitor checking every alu_start against queued expectations.
module tb_calc_sequencer;

    localparam int NDIG = 4;
    localparam int TO   = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        alu_start;
    logic [1:0]  alu_op;
    logic [15:0] operand_a;
    logic [15:0] operand_b;
    logic        alu_done;
    logic        alu_err;
    logic [15:0] alu_result;
    logic [15:0] display;
    logic [2:0]  digit_count;
    logic        error;
    logic [2:0]  state_dbg;

    calc_sequencer #(.NDIG(NDIG), .ALU_TIMEOUT(TO)) dut (
        .clk(clk),
        .reset(reset),
        .key_valid(key_valid),
        .key_code(key_code),
        .alu_start(alu_start),
        .alu_op(alu_op),
        .operand_a(operand_a),
        .operand_b(operand_b),
        .alu_done(alu_done),
        .alu_err(alu_err),
        .alu_result(alu_result),
        .display(display),
        .digit_count(digit_count),
        .error(error),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
    } txn_t;

    txn_t q[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every start pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && alu_start) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_start: a=%h b=%h op=%0d",
                         operand_a, operand_b, alu_op);
            end else begin
                txn_t t;
                t = q.pop_front();
                chk("start_a", 32'(operand_a), 32'(t.a));
                chk("start_b", 32'(operand_b), 32'(t.b));
                chk("start_op", 32'(alu_op), 32'(t.op));
            end
        end
    end

    task automatic press(input logic [3:0] c);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = c;
        @(negedge clk);
        key_valid = 1'b0;
        @(negedge clk);
    endtask

    // Press equals and return at the negedge where alu_start is seen.
    task automatic press_eq(input string name);
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 4'hE;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            key_valid = 1'b0;
            if (alu_start) begin
                seen = 1'b1;
                break;
            end
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    task automatic respond(input logic e, input logic [15:0] r);
        repeat (3) @(negedge clk);
        alu_done   = 1'b1;
        alu_err    = e;
        alu_result = r;
        @(negedge clk);
        alu_done   = 1'b0;
        alu_err    = 1'b0;
        alu_result = 16'h0;
        @(negedge clk);
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] op);
        txn_t t;
        t.a  = a;
        t.b  = b;
        t.op = op;
        q.push_back(t);
    endtask

    initial begin
        int k;
        reset      = 1'b1;
        key_valid  = 1'b0;
        key_code   = 4'h0;
        alu_done   = 1'b0;
        alu_err    = 1'b0;
        alu_result = 16'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        chk("rst_state", 32'(state_dbg), 32'd0);
        chk("rst_display", 32'(display), 32'h0);
        chk("rst_dc", 32'(digit_count), 32'd0);
        chk("rst_outs", {error, alu_start, alu_op, operand_a, operand_b},
            32'h0);

        // 12 + 3 =
        press(4'h1);
        press(4'h2);
        press(4'hA);
        press(4'h3);
        push(16'h0012, 16'h0003, 2'd0);
        press_eq("add_start");
        respond(1'b0, 16'h0015);
        chk("add_display", 32'(display), 32'h0015);
        chk("add_state", 32'(state_dbg), 32'd5);

        // Digit from SHOW starts a fresh operand; fifth digit ignored.
        press(4'h1);
        chk("show_digit_dc", 32'(digit_count), 32'd1);
        chk("show_digit_state", 32'(state_dbg), 32'd0);
        chk("show_digit_b", 32'(operand_b), 32'h0);
        press(4'h2);
        press(4'h3);
        press(4'h4);
        press(4'h5);
        chk("full_a", 32'(operand_a), 32'h1234);
        chk("full_dc", 32'(digit_count), 32'd4);
        chk("full_display", 32'(display), 32'h1234);

        // Long hold produces one event.
        press(4'hF);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 4'h7;
        repeat (50) @(negedge clk);
        key_valid = 1'b0;
        @(negedge clk);
        chk("hold_a", 32'(operand_a), 32'h0007);
        chk("hold_dc", 32'(digit_count), 32'd1);

        // 9 / 0 = with ALU error.
        press(4'hF);
        press(4'h9);
        press(4'hD);
        press(4'h0);
        push(16'h0009, 16'h0000, 2'd3);
        press_eq("div_start");
        respond(1'b1, 16'h0000);
        chk("err_flag", 32'(error), 32'd1);
        chk("err_display", 32'(display), 32'hFFFF);
        press(4'h5);
        press(4'hE);
        chk("err_sticky", {29'd0, state_dbg}, 32'd6);
        chk("err_display2", 32'(display), 32'hFFFF);
        press(4'hF);
        chk("clr_state", 32'(state_dbg), 32'd0);
        chk("clr_regs", {operand_a, operand_b}, 32'h0);
        chk("clr_misc", {26'd0, error, digit_count, alu_op}, 32'h0);
        chk("clr_display", 32'(display), 32'h0);

        // Timeout; a clear key during WAIT_ALU is ignored.
        press(4'h1);
        press(4'hA);
        press(4'h1);
        push(16'h0001, 16'h0001, 2'd0);
        press_eq("to_start");
        k = 0;
        for (int i = 1; i <= TO + 20; i++) begin
            @(negedge clk);
            if (i == 10) begin
                key_valid = 1'b1;
                key_code  = 4'hF;
            end
            if (i == 12) key_valid = 1'b0;
            if (error) begin
                k = i;
                break;
            end
        end
        chk("to_cycles", 32'(k), 32'(TO));
        chk("to_display", 32'(display), 32'hFFFF);
        press(4'hF);

        // Reset during WAIT_ALU, then a stray alu_done.
        press(4'h2);
        press(4'hB);
        press(4'h1);
        push(16'h0002, 16'h0001, 2'd1);
        press_eq("rst_start");
        repeat (4) @(negedge clk);
        chk("rst_in_wait", 32'(state_dbg), 32'd4);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_abort_state", 32'(state_dbg), 32'd0);
        chk("rst_abort_regs", {operand_a, operand_b}, 32'h0);
        chk("rst_abort_misc", {27'd0, alu_op, digit_count}, 32'h0);
        respond(1'b0, 16'h9999);
        chk("stray_state", 32'(state_dbg), 32'd0);
        chk("stray_display", 32'(display), 32'h0);

        // Operator rules: ignored with no digits, replaceable in ENTER_B.
        press(4'hA);
        chk("op_ignored", 32'(state_dbg), 32'd0);
        press(4'h3);
        press(4'hA);
        press(4'hE);
        chk("eq_ignored", 32'(state_dbg), 32'd2);
        press(4'hC);
        chk("op_replaced", 32'(alu_op), 32'd2);
        press(4'h4);
        chk("b_display", 32'(display), 32'h0004);
        push(16'h0003, 16'h0004, 2'd2);
        press_eq("mul_start");
        respond(1'b0, 16'h0012);
        chk("mul_display", 32'(display), 32'h0012);

`ifdef CALC_CHAIN_EN
        press(4'hF);
        press(4'h1);
        press(4'h2);
        press(4'hA);
        press(4'h3);
        push(16'h0012, 16'h0003, 2'd0);
        press_eq("chain_first");
        respond(1'b0, 16'h0015);
        press(4'hB);
        chk("chain_state", 32'(state_dbg), 32'd1);
        chk("chain_a", 32'(operand_a), 32'h0015);
        press(4'h5);
        chk("chain_b_state", 32'(state_dbg), 32'd2);
        push(16'h0015, 16'h0005, 2'd1);
        press_eq("chain_start");
        respond(1'b0, 16'h0010);
        chk("chain_display", 32'(display), 32'h0010);
`else
        press(4'hA);
        chk("show_op_ignored", 32'(state_dbg), 32'd5);
        chk("show_op_display", 32'(display), 32'h0012);
`endif

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
